tblink_rpc_invoke_initiator: RTL and testbench

//  HDL-side initiator for TbLink RPC calls into the remote endpoint.
//  - Accepts method invocations from user logic and assigns each a call_id.
//  - Emits them on the invoke channel and tracks outstanding calls.
//  - Matches returning responses by call_id; responses may arrive out of order.
//  - Delivers {call_id, retval} back to user logic.

---
 rtl/tblink_rpc_invoke_initiator_if.sv | 57 +++++
 rtl/tblink_rpc_invoke_initiator.sv | 137 +++++++++++++
 tb/tb_tblink_rpc_invoke_initiator.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tblink_rpc_invoke_initiator_if.sv
// Handshake bundle for the TbLink RPC invoke initiator: user request/completion
// channels, endpoint invoke/response channels and status outputs.
interface tblink_rpc_invoke_initiator_if #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned METHOD_W = 8,
    parameter int unsigned PARAM_W  = 64,
    parameter int unsigned RET_W    = 64
);
    logic                req_valid;
    logic                req_ready;
    logic [METHOD_W-1:0] req_method;
    logic [PARAM_W-1:0]  req_params;
    logic [ID_W-1:0]     req_call_id;

    logic                inv_valid;
    logic                inv_ready;
    logic [ID_W-1:0]     inv_call_id;
    logic [METHOD_W-1:0] inv_method;
    logic [PARAM_W-1:0]  inv_params;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_call_id;
    logic [RET_W-1:0]    rsp_retval;

    logic                done_valid;
    logic                done_ready;
    logic [ID_W-1:0]     done_call_id;
    logic [RET_W-1:0]    done_retval;

    logic [ID_W:0]       outstanding;
    logic                err_unknown_id;

    modport master (
        input  req_valid, req_method, req_params,
        output req_ready, req_call_id,
        output inv_valid, inv_call_id, inv_method, inv_params,
        input  inv_ready,
        input  rsp_valid, rsp_call_id, rsp_retval,
        output rsp_ready,
        output done_valid, done_call_id, done_retval,
        input  done_ready,
        output outstanding, err_unknown_id
    );

    modport slave (
        output req_valid, req_method, req_params,
        input  req_ready, req_call_id,
        input  inv_valid, inv_call_id, inv_method, inv_params,
        output inv_ready,
        output rsp_valid, rsp_call_id, rsp_retval,
        input  rsp_ready,
        input  done_valid, done_call_id, done_retval,
        output done_ready,
        input  outstanding, err_unknown_id
    );
endinterface

// File: rtl/tblink_rpc_invoke_initiator.sv
// TbLink RPC invoke initiator: allocates call ids, forwards invokes to the endpoint
// and matches out-of-order responses back to user completions.
module tblink_rpc_invoke_initiator #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned METHOD_W = 8,
    parameter int unsigned PARAM_W  = 64,
    parameter int unsigned RET_W    = 64
) (
    input logic                          clock,
    input logic                          reset_n,
    tblink_rpc_invoke_initiator_if.master bus
);
    localparam int unsigned NumIds = 2 ** ID_W;
    localparam logic [ID_W:0] CntOne = {{ID_W{1'b0}}, 1'b1};

    typedef enum logic {StEmpty, StFull} inv_state_e;

    inv_state_e          inv_state_q, inv_state_d;
    logic [ID_W-1:0]     inv_id_q, inv_id_d;
    logic [METHOD_W-1:0] inv_method_q, inv_method_d;
    logic [PARAM_W-1:0]  inv_params_q, inv_params_d;

    logic [NumIds-1:0]   busy_q, busy_d;
    logic [ID_W:0]       outstanding_q, outstanding_d;

    logic                done_valid_q, done_valid_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [RET_W-1:0]    done_ret_q, done_ret_d;
    logic                err_q, err_d;

    logic [ID_W-1:0]     free_id;
    logic                any_free;
    logic                inv_valid, inv_drain, req_ready, req_fire;
    logic                rsp_ready, rsp_fire, rsp_known, rsp_hit;

    // Lowest free id, from the registered bitmap so a same-cycle release is not reused.
    always_comb begin
        free_id  = '0;
        any_free = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            if (!any_free && !busy_q[i]) begin
                free_id  = ID_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign inv_valid = (inv_state_q == StFull);
    assign inv_drain = inv_valid && bus.inv_ready;
    assign req_ready = any_free && (!inv_valid || bus.inv_ready);
    assign req_fire  = bus.req_valid && req_ready;
    assign rsp_ready = !done_valid_q || bus.done_ready;
    assign rsp_fire  = bus.rsp_valid && rsp_ready;
    assign rsp_known = busy_q[bus.rsp_call_id];
    assign rsp_hit   = rsp_fire && rsp_known;

    always_comb begin
        inv_state_d  = inv_state_q;
        inv_id_d     = inv_id_q;
        inv_method_d = inv_method_q;
        inv_params_d = inv_params_q;
        case (inv_state_q)
            StEmpty: if (req_fire) inv_state_d = StFull;
            StFull:  if (inv_drain && !req_fire) inv_state_d = StEmpty;
            default: inv_state_d = StEmpty;
        endcase
        if (req_fire) begin
            inv_id_d     = free_id;
            inv_method_d = bus.req_method;
            inv_params_d = bus.req_params;
        end
    end

    // Allocate and release never target the same id: one is free, the other busy.
    always_comb begin
        busy_d = busy_q;
        if (req_fire) busy_d[free_id] = 1'b1;
        if (rsp_hit)  busy_d[bus.rsp_call_id] = 1'b0;
        case ({req_fire, rsp_hit})
            2'b10:   outstanding_d = outstanding_q + CntOne;
            2'b01:   outstanding_d = outstanding_q - CntOne;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        done_valid_d = done_valid_q;
        done_id_d    = done_id_q;
        done_ret_d   = done_ret_q;
        if (done_valid_q && bus.done_ready) done_valid_d = 1'b0;
        if (rsp_hit) begin
            done_valid_d = 1'b1;
            done_id_d    = bus.rsp_call_id;
            done_ret_d   = bus.rsp_retval;
        end
        err_d = rsp_fire && !rsp_known;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inv_state_q   <= StEmpty;
            inv_id_q      <= '0;
            inv_method_q  <= '0;
            inv_params_q  <= '0;
            busy_q        <= '0;
            outstanding_q <= '0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_ret_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            inv_state_q   <= inv_state_d;
            inv_id_q      <= inv_id_d;
            inv_method_q  <= inv_method_d;
            inv_params_q  <= inv_params_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            done_valid_q  <= done_valid_d;
            done_id_q     <= done_id_d;
            done_ret_q    <= done_ret_d;
            err_q         <= err_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.req_call_id    = free_id;
    assign bus.inv_valid      = inv_valid;
    assign bus.inv_call_id    = inv_id_q;
    assign bus.inv_method     = inv_method_q;
    assign bus.inv_params     = inv_params_q;
    assign bus.rsp_ready      = rsp_ready;
    assign bus.done_valid     = done_valid_q;
    assign bus.done_call_id   = done_id_q;
    assign bus.done_retval    = done_ret_q;
    assign bus.outstanding    = outstanding_q;
    assign bus.err_unknown_id = err_q;
endmodule

// File: tb/tb_tblink_rpc_invoke_initiator.sv
// Scoreboard bench for tblink_rpc_invoke_initiator with ID_W=2: directed calls push
// expected invokes/completions, a negedge monitor pops and compares on each handshake.
module tb_tblink_rpc_invoke_initiator;
    localparam int unsigned ID_W = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [7:0]  m;
        logic [63:0] p;
    } inv_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] r;
    } done_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    inv_t  exp_inv[$];
    done_t exp_done[$];

    tblink_rpc_invoke_initiator_if #(
        .ID_W(ID_W), .METHOD_W(8), .PARAM_W(64), .RET_W(64)
    ) bus ();

    tblink_rpc_invoke_initiator #(
        .ID_W(ID_W), .METHOD_W(8), .PARAM_W(64), .RET_W(64)
    ) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        inv_t  ei;
        done_t ed;
        if (reset_n && bus.inv_valid && bus.inv_ready) begin
            if (exp_inv.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inv_unexpected: got id %0d expected no invoke", bus.inv_call_id);
            end else begin
                ei = exp_inv.pop_front();
                check("inv_call_id", 64'(bus.inv_call_id), 64'(ei.id));
                check("inv_method", 64'(bus.inv_method), 64'(ei.m));
                check("inv_params", bus.inv_params, ei.p);
            end
        end
        if (reset_n && bus.done_valid && bus.done_ready) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got id %0d expected no completion",
                         bus.done_call_id);
            end else begin
                ed = exp_done.pop_front();
                check("done_call_id", 64'(bus.done_call_id), 64'(ed.id));
                check("done_retval", bus.done_retval, ed.r);
            end
        end
    end

    task automatic do_req(input logic [7:0] m, input logic [63:0] p, input logic [1:0] exp_id);
        bit ok = 0;
        bus.req_valid  = 1'b1;
        bus.req_method = m;
        bus.req_params = p;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready 0 expected 1 within 50 cycles");
        end else begin
            check("req_call_id", 64'(bus.req_call_id), 64'(exp_id));
            exp_inv.push_back('{id: exp_id, m: m, p: p});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_rsp(input logic [1:0] id, input logic [63:0] r, input bit known);
        bit ok = 0;
        bus.rsp_valid   = 1'b1;
        bus.rsp_call_id = id;
        bus.rsp_retval  = r;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got rsp_ready 0 expected 1 within 50 cycles");
        end else if (known) begin
            exp_done.push_back('{id: id, r: r});
        end
        @(posedge clk);
        #1;
        bus.rsp_valid = 1'b0;
        if (ok && !known) begin
            @(negedge clk);
            check("err_pulse", 64'(bus.err_unknown_id), 64'd1);
            check("err_no_done", 64'(bus.done_valid), 64'd0);
            @(negedge clk);
            check("err_single_cycle", 64'(bus.err_unknown_id), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_method  = '0;
        bus.req_params  = '0;
        bus.inv_ready   = 1'b1;
        bus.rsp_valid   = 1'b0;
        bus.rsp_call_id = '0;
        bus.rsp_retval  = '0;
        bus.done_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_inv_valid", 64'(bus.inv_valid), 64'd0);
        check("rst_done_valid", 64'(bus.done_valid), 64'd0);
        check("rst_err", 64'(bus.err_unknown_id), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single call
        do_req(8'h05, 64'h1234, 2'd0);
        @(negedge clk);
        check("t1_inv_valid_n1", 64'(bus.inv_valid), 64'd1);
        check("t1_outstanding_1", 64'(bus.outstanding), 64'd1);
        @(posedge clk);
        #1;
        do_rsp(2'd0, 64'hAB, 1);
        @(negedge clk);
        check("t1_done_valid_n1", 64'(bus.done_valid), 64'd1);
        check("t1_outstanding_0", 64'(bus.outstanding), 64'd0);
        @(posedge clk);
        #1;

        // Fill all four ids
        do_req(8'h01, 64'h11, 2'd0);
        do_req(8'h02, 64'h22, 2'd1);
        do_req(8'h03, 64'h33, 2'd2);
        do_req(8'h04, 64'h44, 2'd3);
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("t2_full_req_ready", 64'(bus.req_ready), 64'd0);
        check("t2_full_outstanding", 64'(bus.outstanding), 64'd4);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        // Release id 3 while full: not reusable in the same cycle
        bus.rsp_valid   = 1'b1;
        bus.rsp_call_id = 2'd3;
        bus.rsp_retval  = 64'h3333;
        @(negedge clk);
        check("t3_release_req_ready", 64'(bus.req_ready), 64'd0);
        check("t3_release_rsp_ready", 64'(bus.rsp_ready), 64'd1);
        exp_done.push_back('{id: 2'd3, r: 64'h3333});
        @(posedge clk);
        #1;
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("t3_after_req_ready", 64'(bus.req_ready), 64'd1);
        check("t3_after_outstanding", 64'(bus.outstanding), 64'd3);
        @(posedge clk);
        #1;

        // Out-of-order responses 2,0,1 with a re-allocation of id 2 in between
        do_rsp(2'd2, 64'h2222, 1);
        do_req(8'h20, 64'h2020, 2'd2);
        fork
            do_rsp(2'd0, 64'h0000_0000_0000_0044, 1);
            do_req(8'h30, 64'h3030, 2'd3);
        join
        @(negedge clk);
        check("t3_simul_outstanding", 64'(bus.outstanding), 64'd3);
        @(posedge clk);
        #1;
        do_rsp(2'd1, 64'h1111, 1);
        do_rsp(2'd2, 64'h2200, 1);
        do_rsp(2'd3, 64'h3300, 1);
        @(negedge clk);
        check("t3_drained_outstanding", 64'(bus.outstanding), 64'd0);
        @(posedge clk);
        #1;

        // Invoke backpressure then back-to-back drain
        bus.inv_ready = 1'b0;
        do_req(8'h10, 64'hA, 2'd0);
        fork
            do_req(8'h11, 64'hB, 2'd1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("t4_hold_valid", 64'(bus.inv_valid), 64'd1);
                    check("t4_hold_id", 64'(bus.inv_call_id), 64'd0);
                    check("t4_hold_method", 64'(bus.inv_method), 64'h10);
                    check("t4_hold_params", bus.inv_params, 64'hA);
                    check("t4_hold_req_ready", 64'(bus.req_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus.inv_ready = 1'b1;
            end
        join
        do_req(8'h12, 64'hC, 2'd2);
        @(negedge clk);
        check("t4_b2b_valid", 64'(bus.inv_valid), 64'd1);
        check("t4_b2b_id", 64'(bus.inv_call_id), 64'd2);
        @(posedge clk);
        #1;

        // Unknown id and done backpressure (ids 0,1,2 busy)
        do_rsp(2'd3, 64'hDEAD, 0);
        @(negedge clk);
        check("t5_unknown_outstanding", 64'(bus.outstanding), 64'd3);
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        do_rsp(2'd0, 64'h55, 1);
        bus.rsp_valid   = 1'b1;
        bus.rsp_call_id = 2'd1;
        bus.rsp_retval  = 64'h66;
        @(negedge clk);
        check("t5_done_held", 64'(bus.done_valid), 64'd1);
        check("t5_rsp_blocked", 64'(bus.rsp_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.done_ready = 1'b1;
        do_rsp(2'd1, 64'h66, 1);
        @(negedge clk);
        check("t5_outstanding", 64'(bus.outstanding), 64'd1);
        @(posedge clk);
        #1;

        // Reset mid-flight with ids 0 and 2 allocated
        bus.inv_ready = 1'b0;
        do_req(8'h40, 64'h4040, 2'd0);
        @(negedge clk);
        check("t6_pre_outstanding", 64'(bus.outstanding), 64'd2);
        check("t6_pre_inv_valid", 64'(bus.inv_valid), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_inv.delete();
        exp_done.delete();
        @(negedge clk);
        check("t6_outstanding", 64'(bus.outstanding), 64'd0);
        check("t6_inv_valid", 64'(bus.inv_valid), 64'd0);
        check("t6_done_valid", 64'(bus.done_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.inv_ready = 1'b1;
        do_req(8'h41, 64'h4141, 2'd0);
        do_rsp(2'd0, 64'h88, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_outstanding", 64'(bus.outstanding), 64'd0);
        check("end_inv_queue", 64'(exp_inv.size()), 64'd0);
        check("end_done_queue", 64'(exp_done.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
